// File: rtl/enc_pkg.sv
// Shared definitions for the encoder family: grant state encoding and a
// constant-friendly ceiling-log2 used to size index ports.
package enc_pkg;

  typedef logic [0:0] enc_state_t;

  localparam enc_state_t IDLE    = 1'b0;
  localparam enc_state_t PRESENT = 1'b1;

  // Smallest r such that 2**r >= value; usable in parameter defaults.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational picker: finds the first set request at or below ptr, searching
// downward and wrapping from 0 back to N-1. The request vector is rotated so
// that position ptr lands on the top bit, a plain find-highest-set runs on the
// rotated vector, and the winning position is rotated back to a real index.
module prio_pick import enc_pkg::*; #(
  parameter int N = 32,
  parameter int W = clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  localparam int W1 = W + 1;
  localparam logic [W1-1:0] N_EXT = W1'(N);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [W1-1:0]  start;
  logic [W-1:0]   hi;
  logic [W1-1:0]  sum;

  // rotated[j] is req[(ptr + 1 + j) mod N], so rotated[N-1] is req[ptr]
  assign doubled = {req, req};
  assign start   = {1'b0, ptr} + W1'(1);
  assign rotated = doubled[start +: N];

  // Highest set bit of the rotated vector is the first request at or below ptr
  always_comb begin
    found = 1'b0;
    hi    = '0;
    for (int j = 0; j < N; j++) begin
      if (rotated[j]) begin
        found = 1'b1;
        hi    = W'(j);
      end
    end
  end

  // Undo the rotation; the sum is at most 2N-1 so one conditional wrap suffices
  always_comb begin
    sum = {1'b0, hi} + start;
    idx = W'((sum >= N_EXT) ? (sum - N_EXT) : sum);
  end

endmodule

// File: rtl/prio_encoder_reg.sv
// Registered priority encoder with a valid/ack handshake. Active-low request
// lines are latched into a pending register; one winning index at a time is
// presented on Z with GS low until the consumer acks it. Selection is either
// fixed (highest index wins) or round-robin below the last served index.
// EI/GS/EO keep the active-low cascade meaning of the older encoders.
module prio_encoder_reg import enc_pkg::*; #(
  parameter int N = 32,
  parameter int W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         EI,
  input  logic [N-1:0] I,
  input  logic         mode,
  input  logic         ack,
  output logic [W-1:0] Z,
  output logic         GS,
  output logic         EO
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  enc_state_t   state;
  enc_state_t   state_next;
  logic [N-1:0] pend;
  logic [N-1:0] pend_next;
  logic [N-1:0] clr;
  logic [W-1:0] ptr;
  logic [W-1:0] pick_ptr;
  logic [W-1:0] pick_idx;
  logic         pick_found;
  logic         grant_rr;
  logic         take_grant;
  logic         accept;

  // Fixed priority is just round-robin searching from the top every time
  assign pick_ptr = mode ? ptr : LAST;

  prio_pick #(
    .N(N),
    .W(W)
  ) u_pick (
    .req  (pend),
    .ptr  (pick_ptr),
    .found(pick_found),
    .idx  (pick_idx)
  );

  // An ack only counts while a grant is shown and the block is enabled
  assign accept     = (state == PRESENT) && ack && !EI;
  assign take_grant = (state == IDLE) && !EI && pick_found;

  // One-hot clear of the index being acknowledged
  always_comb begin
    clr = '0;
    if (accept) begin
      clr[Z] = 1'b1;
    end
  end

  // New requests are ORed in after the clear, so a held request re-pends
  always_comb begin
    pend_next = pend;
    if (!EI) begin
      pend_next = (pend & ~clr) | ~I;
    end
  end

  // Grant FSM: a grant always drops back to IDLE, forcing an idle gap
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take_grant) begin
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (EI || ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and pending register; reset drops any grant and all pending work
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
    end else begin
      state <= state_next;
      pend  <= pend_next;
    end
  end

  // Z and the grant's mode are captured only when a grant is issued
  always_ff @(posedge clk) begin
    if (rst) begin
      Z        <= '0;
      grant_rr <= 1'b0;
    end else if (take_grant) begin
      Z        <= pick_idx;
      grant_rr <= mode;
    end
  end

  // Round-robin pointer moves just below an acknowledged round-robin grant
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= LAST;
    end else if (accept && grant_rr) begin
      ptr <= (Z == '0) ? LAST : (Z - W'(1));
    end
  end

  // Registered active-low flags derived from where the FSM and pending go next
  always_ff @(posedge clk) begin
    if (rst) begin
      GS <= 1'b1;
      EO <= 1'b1;
    end else begin
      GS <= (state_next != PRESENT);
      EO <= !(!EI && (state_next == IDLE) && (pend_next == '0));
    end
  end

endmodule
